mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 21 ++
 rtl/mem_arbiter.sv | 136 +++++++++++++
 tb/tb_mem_arbiter.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared arbiter state encodings, state enum and pending-request record.
package mem_arbiter_pkg;
    localparam int PKG_XLEN = 32;
    localparam logic [1:0] ENC_IDLE  = 2'd0;
    localparam logic [1:0] ENC_IBUSY = 2'd1;
    localparam logic [1:0] ENC_DBUSY = 2'd2;
    typedef enum logic [1:0] {
        IDLE  = ENC_IDLE,
        IBUSY = ENC_IBUSY,
        DBUSY = ENC_DBUSY
    } state_e;
    typedef struct packed {
        logic                valid;
        logic                fence;
        logic                spec;
        logic                instr;
        logic [PKG_XLEN-1:0] addr;
        logic [PKG_XLEN-1:0] wdata;
        logic [3:0]          wstrb;
    } req_t;
endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-source (fetch/load-store) arbiter onto one memory port, one access in flight.
// Define MEM_ARBITER_RR_EN for round-robin on contention; default is fixed dmem priority.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int XLEN = PKG_XLEN
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            imem_valid,
    input  logic            imem_fence,
    input  logic            imem_spec,
    input  logic            imem_instr,
    input  logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_wdata,
    input  logic [3:0]      imem_wstrb,
    output logic [XLEN-1:0] imem_rdata,
    output logic            imem_ready,
    input  logic            dmem_valid,
    input  logic            dmem_fence,
    input  logic            dmem_spec,
    input  logic            dmem_instr,
    input  logic [XLEN-1:0] dmem_addr,
    input  logic [XLEN-1:0] dmem_wdata,
    input  logic [3:0]      dmem_wstrb,
    output logic [XLEN-1:0] dmem_rdata,
    output logic            dmem_ready,
    output logic            mem_valid,
    output logic            mem_fence,
    output logic            mem_spec,
    output logic            mem_instr,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [3:0]      mem_wstrb,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_ready
);
    state_e state_q, state_d;
    req_t   pend_i_q, pend_i_d, pend_d_q, pend_d_d, cur_q, cur_d;
    req_t   in_i, in_d, req_i, req_d, win;
    logic   kill_q, kill_d, live_i, live_d, pick_d;
`ifdef MEM_ARBITER_RR_EN
    logic   last_d_q, last_d_d;
`endif

    always_comb begin
        in_i = '{valid: imem_valid, fence: imem_fence, spec: imem_spec, instr: imem_instr,
                 addr: imem_addr, wdata: imem_wdata, wstrb: imem_wstrb};
        in_d = '{valid: dmem_valid, fence: dmem_fence, spec: dmem_spec, instr: dmem_instr,
                 addr: dmem_addr, wdata: dmem_wdata, wstrb: dmem_wstrb};
        // a squash without a replacement request kills the pending fetch this cycle
        live_i = imem_valid | (pend_i_q.valid & ~imem_spec);
        live_d = dmem_valid | pend_d_q.valid;
        req_i  = imem_valid ? in_i : pend_i_q;
        req_d  = dmem_valid ? in_d : pend_d_q;
`ifdef MEM_ARBITER_RR_EN
        pick_d   = live_d & (~live_i | ~last_d_q);
        last_d_d = last_d_q;
`else
        pick_d   = live_d;
`endif
        win        = pick_d ? req_d : req_i;
        state_d    = state_q;
        cur_d      = cur_q;
        kill_d     = kill_q;
        pend_i_d   = imem_valid ? in_i : (imem_spec ? '0 : pend_i_q);
        pend_d_d   = dmem_valid ? in_d : pend_d_q;
        mem_valid  = 1'b0;
        mem_fence  = 1'b0;
        mem_spec   = 1'b0;
        mem_instr  = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_wstrb  = '0;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        imem_rdata = '0;
        dmem_rdata = '0;
        if (state_q == IDLE) begin
            if (live_i | live_d) begin
                mem_valid = 1'b1;
                mem_fence = win.fence;
                mem_spec  = win.spec;
                mem_instr = win.instr;
                mem_addr  = win.addr;
                mem_wdata = win.wdata;
                mem_wstrb = win.wstrb;
                cur_d     = win;
                state_d   = pick_d ? DBUSY : IBUSY;
                pend_d_d  = pick_d ? '0 : pend_d_d;
                pend_i_d  = pick_d ? pend_i_d : '0;
`ifdef MEM_ARBITER_RR_EN
                last_d_d  = pick_d;
`endif
            end
        end else begin
            mem_valid = 1'b1;
            mem_spec  = cur_q.spec;
            mem_instr = cur_q.instr;
            mem_addr  = cur_q.addr;
            mem_wdata = cur_q.wdata;
            mem_wstrb = cur_q.wstrb;
            kill_d    = kill_q | ((state_q == IBUSY) & imem_spec);
            if (mem_ready) begin
                state_d    = IDLE;
                kill_d     = 1'b0;
                imem_ready = (state_q == IBUSY) & ~(kill_q | imem_spec);
                dmem_ready = (state_q == DBUSY);
                imem_rdata = imem_ready ? mem_rdata : '0;
                dmem_rdata = dmem_ready ? mem_rdata : '0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            pend_i_q <= '0;
            pend_d_q <= '0;
            cur_q    <= '0;
            kill_q   <= 1'b0;
`ifdef MEM_ARBITER_RR_EN
            last_d_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            pend_i_q <= pend_i_d;
            pend_d_q <= pend_d_d;
            cur_q    <= cur_d;
            kill_q   <= kill_d;
`ifdef MEM_ARBITER_RR_EN
            last_d_q <= last_d_d;
`endif
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of issue, contention, squash, store hold and reset abandonment.
module tb_mem_arbiter;
    logic        clock = 1'b0;
    logic        reset;
    logic        imem_valid, imem_fence, imem_spec, imem_instr;
    logic [31:0] imem_addr, imem_wdata, imem_rdata;
    logic [3:0]  imem_wstrb;
    logic        imem_ready;
    logic        dmem_valid, dmem_fence, dmem_spec, dmem_instr;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_ready;
    logic        mem_valid, mem_fence, mem_spec, mem_instr;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    int          passed = 0;
    int          total  = 0;

    mem_arbiter #(.XLEN(32)) dut (
        .clock(clock), .reset(reset),
        .imem_valid(imem_valid), .imem_fence(imem_fence), .imem_spec(imem_spec),
        .imem_instr(imem_instr), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .imem_wstrb(imem_wstrb), .imem_rdata(imem_rdata), .imem_ready(imem_ready),
        .dmem_valid(dmem_valid), .dmem_fence(dmem_fence), .dmem_spec(dmem_spec),
        .dmem_instr(dmem_instr), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_wstrb(dmem_wstrb), .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
        .mem_valid(mem_valid), .mem_fence(mem_fence), .mem_spec(mem_spec),
        .mem_instr(mem_instr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
        else passed++;
    endtask

    task automatic idle_in();
        {imem_valid, imem_fence, imem_spec, imem_instr} = '0;
        {dmem_valid, dmem_fence, dmem_spec, dmem_instr} = '0;
        imem_addr = '0; imem_wdata = '0; imem_wstrb = '0;
        dmem_addr = '0; dmem_wdata = '0; dmem_wstrb = '0;
        mem_ready = 1'b0; mem_rdata = '0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // request already visible in IDLE: check its issue, then complete it after one wait cycle
    task automatic serve(input string tag, input logic [31:0] addr, input logic is_d);
        #1;
        chk({tag, "_valid"}, {31'd0, mem_valid}, 32'd1);
        chk({tag, "_addr"}, mem_addr, addr);
        tick();
        idle_in();
        mem_ready = 1'b1;
        mem_rdata = addr ^ 32'h5A5A_0000;
        #1;
        chk({tag, "_rdy"}, {31'd0, is_d ? dmem_ready : imem_ready}, 32'd1);
        chk({tag, "_other"}, {31'd0, is_d ? imem_ready : dmem_ready}, 32'd0);
        chk({tag, "_rdata"}, is_d ? dmem_rdata : imem_rdata, addr ^ 32'h5A5A_0000);
        tick();
        mem_ready = 1'b0;
    endtask

    initial begin
        idle_in();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("rst_valid", {31'd0, mem_valid}, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_ready", {30'd0, imem_ready, dmem_ready}, 32'd0);
        tick();
        imem_valid = 1'b1; imem_addr = 32'h100; imem_instr = 1'b1; imem_fence = 1'b1;
        #1;
        chk("f_issue_fence", {31'd0, mem_fence}, 32'd1);
        chk("f_issue_instr", {31'd0, mem_instr}, 32'd1);
        chk("f_issue_addr", mem_addr, 32'h100);
        tick();
        idle_in();
        #1;
        chk("f_busy_fence", {31'd0, mem_fence}, 32'd0);
        chk("f_busy_addr", mem_addr, 32'h100);
        mem_ready = 1'b1; mem_rdata = 32'h13;
        #1;
        chk("f_rdy", {31'd0, imem_ready}, 32'd1);
        chk("f_rdata", imem_rdata, 32'h13);
        chk("f_drdy", {31'd0, dmem_ready}, 32'd0);
        tick();
        mem_ready = 1'b0;
        #1;
        chk("f_idle", {31'd0, mem_valid}, 32'd0);
        mem_ready = 1'b1;
        #1;
        chk("spur_ready", {30'd0, imem_ready, dmem_ready}, 32'd0);
        tick();
        mem_ready = 1'b0;
        #1;
        chk("spur_idle", {31'd0, mem_valid}, 32'd0);
        imem_valid = 1'b1; imem_addr = 32'h200;
        dmem_valid = 1'b1; dmem_addr = 32'h8000;
        serve("c1d", 32'h8000, 1'b1);
        serve("c1i", 32'h200, 1'b0);
        imem_valid = 1'b1; imem_addr = 32'h204;
        dmem_valid = 1'b1; dmem_addr = 32'h8008;
        serve("c2d", 32'h8008, 1'b1);
        serve("c2i", 32'h204, 1'b0);
        dmem_valid = 1'b1; dmem_addr = 32'h8010;
        serve("solo_d", 32'h8010, 1'b1);
        imem_valid = 1'b1; imem_addr = 32'h210;
        dmem_valid = 1'b1; dmem_addr = 32'h8020;
`ifdef MEM_ARBITER_RR_EN
        serve("c3i", 32'h210, 1'b0);
        serve("c3d", 32'h8020, 1'b1);
`else
        serve("c3d", 32'h8020, 1'b1);
        serve("c3i", 32'h210, 1'b0);
`endif
        imem_valid = 1'b1; imem_addr = 32'h300;
        #1;
        chk("sq_issue", mem_addr, 32'h300);
        tick();
        imem_valid = 1'b1; imem_spec = 1'b1; imem_addr = 32'h400;
        tick();
        idle_in();
        mem_ready = 1'b1; mem_rdata = 32'hBAD;
        #1;
        chk("sq_hold", mem_addr, 32'h300);
        chk("sq_killed", {31'd0, imem_ready}, 32'd0);
        tick();
        mem_ready = 1'b0;
        serve("sq_new", 32'h400, 1'b0);
        dmem_valid = 1'b1; dmem_addr = 32'h8004; dmem_wdata = 32'hDEADBEEF; dmem_wstrb = 4'hF;
        #1;
        chk("st_issue", mem_addr, 32'h8004);
        tick();
        idle_in();
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("st_wstrb", {28'd0, mem_wstrb}, 32'hF);
            chk("st_wdata", mem_wdata, 32'hDEADBEEF);
            chk("st_addr", mem_addr, 32'h8004);
            tick();
        end
        mem_ready = 1'b1;
        #1;
        chk("st_rdy", {31'd0, dmem_ready}, 32'd1);
        tick();
        mem_ready = 1'b0;
        dmem_valid = 1'b1; dmem_addr = 32'h8008;
        tick();
        idle_in();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("mr_valid", {31'd0, mem_valid}, 32'd0);
        mem_ready = 1'b1;
        #1;
        chk("mr_late", {30'd0, imem_ready, dmem_ready}, 32'd0);
        tick();
        mem_ready = 1'b0;
        #1;
        chk("mr_idle", {31'd0, mem_valid}, 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
